keypad_scanner: RTL
===================

# keypad_scanner

Drives the column lines of a 4x4 keypad matrix and samples the row lines returned through it. The block walks a one-hot column pattern and waits a settle time on each column. When it sees a pressed row, it debounces the press, reports one encoded key event, and holds the column until release. It sits between the keypad pins and the display/entry logic and is the driving counterpart of the row debouncing path.

## Interface
- SETTLE_CYCLES, 4: cycles each column is driven before rows are sampled; must be >= 1.
- DEBOUNCE_CYCLES, 60: consecutive stable cycles required to accept a press or a release; must be >= 1.
- clk  input  1  system clock.
- nrst  input  1  reset, synchronous, active-low.
- row  input  4  raw row lines; 1 = pressed key connects the driven column to that row.
- col  output  4  one-hot active-high column drive.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high from acceptance until the release is debounced.

## Operation
- Reset values: col=4'b0001, col_idx=0, state SCAN, counter=0, key_code=0, key_valid=0, key_held=0.
- The counter is unsigned and has width $clog2(max(SETTLE_CYCLES, DEBOUNCE_CYCLES)+1). It is cleared on every state change.
- row_s is the row vector used by the state machine (see Configuration).
- SCAN:
  - counter increments each cycle.
  - At counter==SETTLE_CYCLES-1 with row_s==0: rotate col left (4'b1000 wraps to 4'b0001), col_idx+1 mod 4, stay in SCAN.
  - At counter==SETTLE_CYCLES-1 with row_s!=0: latch row_idx as the lowest set bit of row_s, then go to DEBOUNCE. col does not change.
- DEBOUNCE:
  - col is held and counter increments.
  - If row_s[row_idx]==0 in any cycle: go to SCAN on the same column.
  - At counter==DEBOUNCE_CYCLES-1 with row_s[row_idx]==1: go to PRESSED.
- PRESSED (exactly one cycle):
  - key_valid=1.
  - key_code={row_idx, col_idx} is registered.
  - key_held goes to 1.
  - Next state is HOLD.
- HOLD:
  - col is held.
  - counter increments while row_s[row_idx]==0 and clears whenever row_s[row_idx]==1.
  - At counter==DEBOUNCE_CYCLES-1 with row still released: key_held=0, advance col/col_idx, go to SCAN.
- Multiple rows pressed on one column: the lowest index wins. Other rows are ignored until release.
- Other columns are never scanned while in DEBOUNCE or HOLD. Second keys pressed during HOLD are not reported.
- key_code keeps its value until the next PRESSED.
- nrst low in any state restores all reset values on the next edge, including a key_held that was high.

## Timing
- All outputs are registered.
- Idle scan period is 4*SETTLE_CYCLES cycles per full rotation.
- key_valid assertion, counted from the first SCAN sample that sees the row high:
  - DEBOUNCE_CYCLES+1 clocks.
  - Plus the Configuration latency from the pin.
- key_valid is high for exactly 1 cycle per accepted press, never back to back.
- key_held falls DEBOUNCE_CYCLES clocks after the first released row_s cycle of an uninterrupted release. col advances on that same edge.
- A bounce shorter than DEBOUNCE_CYCLES during DEBOUNCE aborts the press and produces no pulse. During HOLD it restarts the release count.

## Configuration
- KEYPAD_SYNC_EN defined: row passes through a 2-flop synchronizer. row_s lags the pins by 2 cycles.
  - The first 2 samples after a column change may still reflect the previous column.
  - SETTLE_CYCLES must therefore be >= 3.
- KEYPAD_SYNC_EN undefined: row_s=row combinationally, 0 cycles added. Use this only for benches or already-synchronized inputs.

## Test plan
- Idle, row=0, SETTLE_CYCLES=4: col steps 0001->0010->0100->1000->0001, changing every 4 cycles. key_valid never asserts.
- Key at row 2, col 1, held 100 cycles, DEBOUNCE_CYCLES=8:
  - exactly one key_valid pulse with key_code=4'b1001;
  - key_held=1 until 8 cycles after release;
  - then col=0100.
- Bounce: row toggles high 3 cycles, low 1, high 3 during DEBOUNCE -> no key_valid. Scanning resumes on the same column.
- Rows 1 and 3 pressed together on col 3 -> key_code=4'b0111, one pulse.
- Release bounce in HOLD: low 5 cycles, high 1, low 8 -> key_held stays 1 through the bounce and falls only after the final 8 low cycles. No second pulse.
- nrst=0 asserted during HOLD -> next edge col=0001, key_held=0, key_code=0, state SCAN.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
//
// Scans a 4x4 keypad matrix by driving one column at a time and sampling
// the row lines that come back. Each column is driven for SETTLE_CYCLES
// before the rows are looked at.
//
// When a row is seen high, the scanner stops on that column. It accepts the
// press only after DEBOUNCE_CYCLES consecutive high cycles on that row, and
// then emits a single key_valid pulse with the encoded key. It then keeps
// the column parked until the release has been stable for DEBOUNCE_CYCLES.
// After that, scanning resumes on the next column.
//
// Parameters:
//   SETTLE_CYCLES   cycles each column is driven before rows are sampled (>= 1,
//                   >= 3 when KEYPAD_SYNC_EN is defined)
//   DEBOUNCE_CYCLES consecutive stable cycles to accept a press or a release (>= 1)
//
// Ports:
//   clk        system clock
//   nrst       synchronous active-low reset
//   row[3:0]   raw row lines, 1 = pressed key connects the driven column
//   col[3:0]   one-hot active-high column drive
//   key_code   {row_idx, col_idx} of the last accepted key
//   key_valid  one-cycle pulse per accepted key
//   key_held   high from acceptance until the release is debounced
//
// Build option:
//   KEYPAD_SYNC_EN  when defined, the rows pass through a 2-flop synchronizer
//                   before the state machine sees them (2 cycles of lag).
//                   When undefined, the rows are used directly.

module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 60
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES
                                                                 : DEBOUNCE_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  logic [3:0]       row_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic [1:0]       lowest_row;
  logic             tracked_row;

`ifdef KEYPAD_SYNC_EN
  // Two-stage synchronizer on the raw pins.
  // Because of it, the first two samples after a column change still
  // show the previous column.
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = row;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign row_s = sync2_q;
`else
  assign row_s = row;
`endif

  // Lowest-index row wins when several keys on one column are down.
  always_comb begin
    lowest_row = 2'd0;
    if (row_s[0]) begin
      lowest_row = 2'd0;
    end else if (row_s[1]) begin
      lowest_row = 2'd1;
    end else if (row_s[2]) begin
      lowest_row = 2'd2;
    end else if (row_s[3]) begin
      lowest_row = 2'd3;
    end
  end

  // Once a row is latched, only that row matters; other rows are ignored.
  assign tracked_row = row_s[row_idx_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          // The counter restarts for every new column, not only on state changes.
          cnt_d = '0;
          if (row_s == 4'b0000) begin
            col_d     = {col_q[2:0], col_q[3]};
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = lowest_row;
            state_d   = ST_DEBOUNCE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (!tracked_row) begin
          // Bounce: give up on this press and rescan the same column.
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else if (cnt_q == DEBOUNCE_LAST) begin
          // key_valid, key_code and key_held are all registered here.
          // This makes them visible during the single PRESSED cycle.
          state_d     = ST_PRESSED;
          cnt_d       = '0;
          key_valid_d = 1'b1;
          key_code_d  = {row_idx_q, col_idx_q};
          key_held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PRESSED: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end

      ST_HOLD: begin
        // Any cycle where the row is still pressed restarts the release count.
        if (tracked_row) begin
          cnt_d = '0;
        end else if (cnt_q == DEBOUNCE_LAST) begin
          state_d    = ST_SCAN;
          cnt_d      = '0;
          key_held_d = 1'b0;
          col_d      = {col_q[2:0], col_q[3]};
          col_idx_d  = col_idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_SCAN;
      cnt_q       <= '0;
      col_q       <= 4'b0001;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
